// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// The state encoding is also visible on the top-level debug port.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement add/subtract, LSB first, one bit per clock.
// Handshake: start is accepted whenever busy=0 (IDLE or DONE); done is high for exactly one cycle when sum/carry/overflow update.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, ps_q;
  logic               c_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q, ovf_q;

  logic               accept, last_bit, msb_cin;
  logic               fa_s, fa_cout;

  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign accept   = start && (state_q != RUN);
  assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);
  // Carry entering the MSB is simply the running carry on the last bit.
  assign msb_cin  = c_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand shifters, running carry, bit counter and partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      ps_q  <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= (sub == MODE_ADD) ? b : ~b;
      c_q   <= (sub == MODE_SUB);
      cnt_q <= '0;
      ps_q  <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      c_q   <= fa_cout;
      cnt_q <= cnt_q + CNT_W'(1);
      ps_q  <= {fa_s, ps_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (last_bit) begin
      sum_q   <= {fa_s, ps_q[WIDTH-1:1]};
      carry_q <= fa_cout;
      ovf_q   <= msb_cin ^ fa_cout;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed WIDTH=8 cases, then random WIDTH=2 and WIDTH=16 traffic.
// Drivers push expected {overflow, carry, sum} and due cycle; per-instance monitors pop on done.
module tb_serial_add_sub;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        start8, sub8, busy8, done8, carry8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic [1:0]  st8;
  logic        start2, sub2, busy2, done2, carry2, ovf2;
  logic [1:0]  a2, b2, sum2;
  logic [1:0]  st2;
  logic        start16, sub16, busy16, done16, carry16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic [1:0]  st16;

  serial_add_sub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ovf8),
    .state_dbg(st8)
  );
  serial_add_sub #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .carry(carry2), .overflow(ovf2),
    .state_dbg(st2)
  );
  serial_add_sub #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .overflow(ovf16),
    .state_dbg(st16)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q8[$];
  logic [31:0] exp_q2[$];
  logic [31:0] exp_q16[$];
  int          due_q8[$];
  int          due_q2[$];
  int          due_q16[$];
  logic [31:0] last8;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain w-bit arithmetic, packed as {overflow, carry, sum}.
  function automatic logic [31:0] model(input int w, input int av, input int bv, input bit s);
    int mask, bb, full, res;
    bit cy, ov, sa, sb, sr;
    mask = (1 << w) - 1;
    bb   = s ? (~bv & mask) : bv;
    full = av + bb + (s ? 1 : 0);
    res  = full & mask;
    cy   = ((full >> w) & 1) != 0;
    sa   = ((av  >> (w - 1)) & 1) != 0;
    sb   = ((bb  >> (w - 1)) & 1) != 0;
    sr   = ((res >> (w - 1)) & 1) != 0;
    ov   = (sa == sb) && (sr != sa);
    return 32'(res) | (32'(cy) << w) | (32'(ov) << (w + 1));
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (exp_q8.size() == 0) check("w8 unexpected done", 32'(done8), 32'd0);
      else begin
        check("w8 result", 32'({ovf8, carry8, sum8}), exp_q8.pop_front());
        check("w8 latency", cyc, due_q8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      if (exp_q2.size() == 0) check("w2 unexpected done", 32'(done2), 32'd0);
      else begin
        check("w2 result", 32'({ovf2, carry2, sum2}), exp_q2.pop_front());
        check("w2 latency", cyc, due_q2.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done16) begin
      if (exp_q16.size() == 0) check("w16 unexpected done", 32'(done16), 32'd0);
      else begin
        check("w16 result", 32'({ovf16, carry16, sum16}), exp_q16.pop_front());
        check("w16 latency", cyc, due_q16.pop_front());
      end
    end
  end

  // ---------------- WIDTH=8 driver tasks ----------------
  // Called at a negedge; returns at the negedge of the first RUN cycle.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic s,
                        input logic [7:0] es, input logic ec, input logic eo);
    logic [31:0] held;
    held   = last8;
    last8  = {22'd0, eo, ec, es};
    a8     = av;
    b8     = bv;
    sub8   = s;
    start8 = 1'b1;
    exp_q8.push_back(last8);
    due_q8.push_back(cyc + 9);
    @(negedge clk);
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    sub8   = 1'($urandom);
    check("w8 busy in run", 32'(busy8), 32'd1);
    check("w8 outputs held in run", 32'({ovf8, carry8, sum8}), held);
  endtask

  task automatic wait_done8();
    int n;
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("w8 done seen", 32'(done8), 32'd1);
  endtask

  task automatic idle_after8();
    @(negedge clk);
    check("w8 idle busy", 32'(busy8), 32'd0);
    check("w8 idle done", 32'(done8), 32'd0);
  endtask

  // ---------------- random drivers ----------------
  task automatic run_rand2(input int n_ops);
    logic [1:0] av, bv;
    logic       s;
    int         n;
    for (int i = 0; i < n_ops; i++) begin
      av = 2'($urandom); bv = 2'($urandom); s = 1'($urandom);
      a2 = av; b2 = bv; sub2 = s; start2 = 1'b1;
      exp_q2.push_back(model(2, int'(av), int'(bv), s));
      due_q2.push_back(cyc + 3);
      @(negedge clk);
      n = 0;
      while (!done2 && n < 20) begin
        a2 = 2'($urandom); b2 = 2'($urandom); sub2 = 1'($urandom);
        start2 = 1'($urandom);
        @(negedge clk);
        n++;
      end
      check("w2 done seen", 32'(done2), 32'd1);
      if ($urandom_range(0, 1) == 1) begin
        start2 = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    start2 = 1'b0;
  endtask

  task automatic run_rand16(input int n_ops);
    logic [15:0] av, bv;
    logic        s;
    int          n;
    for (int i = 0; i < n_ops; i++) begin
      av = 16'($urandom); bv = 16'($urandom); s = 1'($urandom);
      a16 = av; b16 = bv; sub16 = s; start16 = 1'b1;
      exp_q16.push_back(model(16, int'(av), int'(bv), s));
      due_q16.push_back(cyc + 17);
      @(negedge clk);
      n = 0;
      while (!done16 && n < 40) begin
        a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
        start16 = 1'($urandom);
        @(negedge clk);
        n++;
      end
      check("w16 done seen", 32'(done16), 32'd1);
      if ($urandom_range(0, 1) == 1) begin
        start16 = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    start16 = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    n_cmp = 0; n_fail = 0; last8 = '0;
    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("reset w8 busy/done", 32'({busy8, done8}), 32'd0);
    check("reset w8 outputs", 32'({ovf8, carry8, sum8}), 32'd0);
    check("reset w2 outputs", 32'({busy2, done2, ovf2, carry2, sum2}), 32'd0);
    check("reset w16 outputs", 32'({busy16, done16, ovf16, carry16, sum16}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=8 arithmetic corners.
    issue8(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0); wait_done8(); idle_after8();
    issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0); wait_done8(); idle_after8();
    issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1); wait_done8(); idle_after8();
    issue8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0); wait_done8(); idle_after8();
    issue8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1); wait_done8(); idle_after8();

    // Start during RUN is dropped; start in DONE chains without a gap.
    issue8(8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h00; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("w8 busy after ignored start", 32'(busy8), 32'd1);
    wait_done8();
    issue8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    wait_done8(); idle_after8();

    // Reset in the 4th RUN cycle aborts the operation.
    issue8(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q8.delete();
    due_q8.delete();
    last8 = '0;
    check("abort busy/done", 32'({busy8, done8}), 32'd0);
    check("abort outputs", 32'({ovf8, carry8, sum8}), 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort stays idle", 32'({busy8, done8}), 32'd0);
    issue8(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0); wait_done8(); idle_after8();

    // Random traffic on the narrow and wide instances in parallel.
    fork
      run_rand2(1000);
      run_rand16(1000);
    join

    n = 0;
    while ((exp_q8.size() + exp_q2.size() + exp_q16.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("w8 outstanding", 32'(exp_q8.size()), 32'd0);
    check("w2 outstanding", 32'(exp_q2.size()), 32'd0);
    check("w16 outstanding", 32'(exp_q16.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
